// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences IF/ID/EX/MEM/WB and
// Moore-decodes datapath enables from the registered state.
module multi_cycle_ctrl #(
   parameter int OP_W = 6,
   parameter int ST_W = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [OP_W-1:0] instr_op_i,
   input  logic            mem_ready_i,
   output logic [2:0]      ALUOp_o,
   output logic            ALUSrcA_o,
   output logic [1:0]      ALUSrcB_o,
   output logic            IRWrite_o,
   output logic            PCWrite_o,
   output logic            PCWriteCond_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic            MemtoReg_o,
   output logic            RegDst_o,
   output logic            RegWrite_o,
   output logic            illegal_o,
   output logic [ST_W-1:0] state_o
);

   typedef enum logic [ST_W-1:0] {
      IDLE    = ST_W'(0),
      IF      = ST_W'(1),
      ID      = ST_W'(2),
      EX_R    = ST_W'(3),
      EX_ADDI = ST_W'(4),
      EX_SLTI = ST_W'(5),
      EX_ADDR = ST_W'(6),
      MEM_RD  = ST_W'(7),
      MEM_WR  = ST_W'(8),
      WB_R    = ST_W'(9),
      WB_I    = ST_W'(10),
      WB_MEM  = ST_W'(11),
      BR      = ST_W'(12)
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);

   state_e state_q, state_d;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign state_o = state_q;

   always_comb begin
      state_d       = IDLE;
      ALUOp_o       = 3'b000;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      IRWrite_o     = 1'b0;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      MemtoReg_o    = 1'b0;
      RegDst_o      = 1'b0;
      RegWrite_o    = 1'b0;
      illegal_o     = 1'b0;
      case (state_q)
         IDLE: state_d = IF;
         IF: begin
            IRWrite_o = 1'b1;
            PCWrite_o = 1'b1;
            ALUSrcB_o = 2'b01;
            state_d   = ID;
         end
         // ALU precomputes the branch target while the opcode is dispatched
         ID: begin
            ALUSrcB_o = 2'b11;
            case (instr_op_i)
               OP_RTYPE:     state_d = EX_R;
               OP_ADDI:      state_d = EX_ADDI;
               OP_SLTI:      state_d = EX_SLTI;
               OP_LW, OP_SW: state_d = EX_ADDR;
               OP_BEQ:       state_d = BR;
               default: begin
                  state_d   = IF;
                  illegal_o = 1'b1;
               end
            endcase
         end
         EX_R: begin
            ALUSrcA_o = 1'b1;
            ALUOp_o   = 3'b010;
            state_d   = WB_R;
         end
         EX_ADDI: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            state_d   = WB_I;
         end
         EX_SLTI: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            ALUOp_o   = 3'b011;
            state_d   = WB_I;
         end
         EX_ADDR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            state_d   = (instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
         end
         // Memory states stall for as long as the handshake stays low
         MEM_RD: begin
            MemRead_o = 1'b1;
            state_d   = mem_ready_i ? WB_MEM : MEM_RD;
         end
         MEM_WR: begin
            MemWrite_o = 1'b1;
            state_d    = mem_ready_i ? IF : MEM_WR;
         end
         WB_R: begin
            RegWrite_o = 1'b1;
            RegDst_o   = 1'b1;
            state_d    = IF;
         end
         WB_I: begin
            RegWrite_o = 1'b1;
            state_d    = IF;
         end
         WB_MEM: begin
            RegWrite_o = 1'b1;
            MemtoReg_o = 1'b1;
            state_d    = IF;
         end
         BR: begin
            ALUSrcA_o     = 1'b1;
            ALUOp_o       = 3'b001;
            PCWriteCond_o = 1'b1;
            state_d       = IF;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: an instruction-level trace model
// predicts every cycle's outputs for table-driven and random instruction streams.
module tb_multi_cycle_ctrl;

   logic       clk;
   logic       rstN;
   logic [5:0] instrOp;
   logic       memReady;
   logic [2:0] aluOp;
   logic       srcA;
   logic [1:0] srcB;
   logic       irWrite, pcWrite, pcWriteCond, memRead, memWrite;
   logic       memToReg, regDst, regWrite, illegal;
   logic [3:0] stateO;
   logic [18:0] actVec;

   int nTests = 0;
   int nFail  = 0;
   bit atIf   = 0;

   logic [18:0] expQ[$];
   bit          memQ[$];

   localparam logic [8:0] F_IRW  = 9'h100;
   localparam logic [8:0] F_PCW  = 9'h080;
   localparam logic [8:0] F_PCWC = 9'h040;
   localparam logic [8:0] F_MR   = 9'h020;
   localparam logic [8:0] F_MW   = 9'h010;
   localparam logic [8:0] F_M2R  = 9'h008;
   localparam logic [8:0] F_RD   = 9'h004;
   localparam logic [8:0] F_RW   = 9'h002;
   localparam logic [8:0] F_ILL  = 9'h001;

   typedef struct {
      logic [5:0] op;
      int         waitCyc;
      int         cpi;
   } vec_t;

   multi_cycle_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rstN),
      .instr_op_i    (instrOp),
      .mem_ready_i   (memReady),
      .ALUOp_o       (aluOp),
      .ALUSrcA_o     (srcA),
      .ALUSrcB_o     (srcB),
      .IRWrite_o     (irWrite),
      .PCWrite_o     (pcWrite),
      .PCWriteCond_o (pcWriteCond),
      .MemRead_o     (memRead),
      .MemWrite_o    (memWrite),
      .MemtoReg_o    (memToReg),
      .RegDst_o      (regDst),
      .RegWrite_o    (regWrite),
      .illegal_o     (illegal),
      .state_o       (stateO)
   );

   assign actVec = {stateO, aluOp, srcA, srcB, irWrite, pcWrite, pcWriteCond,
                    memRead, memWrite, memToReg, regDst, regWrite, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observable cycle packed as {state, ALUOp, SrcA, SrcB, enable flags}
   function automatic logic [18:0] cyc(input int st, input logic [2:0] alu,
                                       input logic a, input logic [1:0] b,
                                       input logic [8:0] f);
      return {4'(st), alu, a, b, f};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushCyc(input logic [18:0] v, input bit isMem);
      expQ.push_back(v);
      memQ.push_back(isMem);
   endtask

   // Instruction-level model: what each instruction class does, phase by phase
   task automatic buildModel(input logic [5:0] op, input int waitCyc);
      logic [18:0] idOk;
      logic [18:0] wbI;
      logic [18:0] exAddr;
      idOk   = cyc(2, 3'b000, 1'b0, 2'b11, 9'h000);
      wbI    = cyc(10, 3'b000, 1'b0, 2'b00, F_RW);
      exAddr = cyc(6, 3'b000, 1'b1, 2'b10, 9'h000);
      expQ.delete();
      memQ.delete();
      pushCyc(cyc(1, 3'b000, 1'b0, 2'b01, F_IRW | F_PCW), 1'b0);
      case (op)
         6'b000000: begin
            pushCyc(idOk, 1'b0);
            pushCyc(cyc(3, 3'b010, 1'b1, 2'b00, 9'h000), 1'b0);
            pushCyc(cyc(9, 3'b000, 1'b0, 2'b00, F_RW | F_RD), 1'b0);
         end
         6'b001000: begin
            pushCyc(idOk, 1'b0);
            pushCyc(cyc(4, 3'b000, 1'b1, 2'b10, 9'h000), 1'b0);
            pushCyc(wbI, 1'b0);
         end
         6'b001010: begin
            pushCyc(idOk, 1'b0);
            pushCyc(cyc(5, 3'b011, 1'b1, 2'b10, 9'h000), 1'b0);
            pushCyc(wbI, 1'b0);
         end
         6'b100011: begin
            pushCyc(idOk, 1'b0);
            pushCyc(exAddr, 1'b0);
            for (int i = 0; i <= waitCyc; i++)
               pushCyc(cyc(7, 3'b000, 1'b0, 2'b00, F_MR), 1'b1);
            pushCyc(cyc(11, 3'b000, 1'b0, 2'b00, F_RW | F_M2R), 1'b0);
         end
         6'b101011: begin
            pushCyc(idOk, 1'b0);
            pushCyc(exAddr, 1'b0);
            for (int i = 0; i <= waitCyc; i++)
               pushCyc(cyc(8, 3'b000, 1'b0, 2'b00, F_MW), 1'b1);
         end
         6'b000100: begin
            pushCyc(idOk, 1'b0);
            pushCyc(cyc(12, 3'b001, 1'b1, 2'b00, F_PCWC), 1'b0);
         end
         default: pushCyc(cyc(2, 3'b000, 1'b0, 2'b11, F_ILL), 1'b0);
      endcase
   endtask

   // Holds reset 3 cycles, releases it and stops at the first IF cycle
   task automatic doReset();
      rstN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         instrOp  = 6'($urandom);
         memReady = 1'($urandom);
         #1 checkOutput("reset hold", 32'(actVec), 32'h0);
      end
      @(negedge clk);
      rstN = 1'b1;
      #1 checkOutput("reset release idle", 32'(actVec), 32'h0);
      @(negedge clk);
      #1 checkOutput("first IF", 32'(actVec),
                     32'(cyc(1, 3'b000, 1'b0, 2'b01, F_IRW | F_PCW)));
      atIf = 1'b1;
   endtask

   // Drives one instruction starting at the current IF cycle, checks every
   // cycle against the model and returns the cycle count until the next IF
   task automatic applyStimulus(input logic [5:0] op, input int waitCyc, output int cpi);
      int memIdx;
      int c;
      buildModel(op, waitCyc);
      memIdx = 0;
      cpi    = -1;
      for (c = 0; c < 64; c++) begin
         if (!(c == 0 && atIf)) begin
            @(negedge clk);
            instrOp  = (c == 0 || c >= expQ.size()) ? 6'($urandom) : op;
            if (c < expQ.size() && memQ[c]) begin
               memReady = (memIdx == waitCyc);
               memIdx++;
            end else begin
               memReady = 1'($urandom);
            end
            #1;
         end
         if (c > 0 && stateO == 4'd1) begin
            cpi = c;
            break;
         end
         if (c >= expQ.size()) break;
         checkOutput($sformatf("op=%b cycle%0d", op, c), 32'(actVec), 32'(expQ[c]));
      end
      checkOutput($sformatf("op=%b cpi", op), 32'(cpi), 32'(expQ.size()));
      if (cpi < 0) begin
         atIf = 1'b0;
         doReset();
      end else begin
         atIf = 1'b1;
      end
   endtask

   initial begin
      vec_t vecs[10];
      logic [5:0] legalOps[6];
      int cpi;

      vecs[0] = '{6'b000000, 0, 4};
      vecs[1] = '{6'b001000, 0, 4};
      vecs[2] = '{6'b001010, 0, 4};
      vecs[3] = '{6'b100011, 2, 7};
      vecs[4] = '{6'b100011, 0, 5};
      vecs[5] = '{6'b101011, 0, 4};
      vecs[6] = '{6'b101011, 1, 5};
      vecs[7] = '{6'b000100, 0, 3};
      vecs[8] = '{6'b111111, 0, 2};
      vecs[9] = '{6'b000001, 0, 2};
      legalOps = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011, 6'b000100};

      rstN     = 1'b0;
      instrOp  = 6'd0;
      memReady = 1'b0;
      doReset();

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].waitCyc, cpi);
         checkOutput($sformatf("table%0d cpi", i), 32'(cpi), 32'(vecs[i].cpi));
      end

      for (int i = 0; i < 40; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legalOps[$urandom_range(0, 5)];
         applyStimulus(op, $urandom_range(0, 3), cpi);
      end

      // Abort a stalled store by asserting reset in the middle of MEM_WR
      @(negedge clk);
      instrOp  = 6'b101011;
      memReady = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 checkOutput("abort MEM_WR active", 32'({stateO, memWrite}), 32'({4'd8, 1'b1}));
      #2 rstN = 1'b0;
      #1 checkOutput("abort outputs cleared", 32'(actVec), 32'h0);
      doReset();
      applyStimulus(6'b000000, 0, cpi);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
